// File: rtl/mem_arb.sv
// mem_arb: shares one single-port memory among NUM_CORES requesting cores.
// One request transfers per cycle (valid/ready). Writes complete at transfer;
// reads return RD_LAT cycles later on a shared data bus, tagged per core by
// a one-hot rsp_valid. Arbitration is round-robin by default.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer).
module mem_arb #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES-1:0]        req_we,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
  output logic [NUM_CORES-1:0]        req_ready,
  output logic                        mem_wen,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [NUM_CORES-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic             rd_fire;

  // Read pipeline: valid bits are control (reset), owner ids ride alongside.
  logic [RD_LAT-1:0] vld_p;
  logic [IDX_W-1:0]  own_p [RD_LAT];

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr;

  // Pick the first valid core searching upward from ptr, wrapping at the top.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!gnt_any && req_valid[(int'(ptr) + k) % NUM_CORES]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'((int'(ptr) + k) % NUM_CORES);
      end
    end
    if (reset) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
  end

  // Advance the pointer just past the winner; hold it when nobody is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      if (gnt_idx == IDX_W'(NUM_CORES - 1)) ptr <= '0;
      else                                  ptr <= gnt_idx + 1'b1;
    end
  end
`else
  // Lowest-index valid core always wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
    if (reset) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
  end
`endif

  // Steer the granted core's request straight onto the memory port.
  always_comb begin
    req_ready = '0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_fire   = 1'b0;
    if (gnt_any) begin
      req_ready = NUM_CORES'(1) << gnt_idx;
      mem_wen   = req_we[gnt_idx];
      mem_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
      mem_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
      rd_fire   = ~req_we[gnt_idx];
    end
  end

  // Shift read-valid flags; reset drops any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_fire;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Shift owner ids alongside the valid flags.
  always_ff @(posedge clk) begin
    own_p[0] <= gnt_idx;
    for (int i = 1; i < RD_LAT; i++) own_p[i] <= own_p[i-1];
  end

  // Return the memory data to the core that issued the read.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (vld_p[RD_LAT-1]) begin
      rsp_valid = NUM_CORES'(1) << own_p[RD_LAT-1];
      rsp_data  = mem_rdata;
    end
  end

endmodule
